// File: rtl/heap_byte_sram_if.sv
// Byte-addressed SRAM access bus for heap_byte_sram.
// Handshake: a request transfers on a rising edge where req=1 and ready=1;
// with ready=0, req and all other master signals are ignored. Read data
// come back later as a one-cycle rvalid pulse with q; there is no
// back-pressure on the return path.
interface heap_byte_sram_if #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 16
);
  logic                    req;
  logic                    wen;
  logic [DATA_BYTES-1:0]   be;
  logic [ADDR_W-1:0]       addr;
  logic [8*DATA_BYTES-1:0] d;
  logic                    ready;
  logic                    rvalid;
  logic [8*DATA_BYTES-1:0] q;

  modport master (output req, wen, be, addr, d, input ready, rvalid, q);
  modport slave  (input req, wen, be, addr, d, output ready, rvalid, q);
endinterface

// File: rtl/heap_byte_sram.sv
// heap_byte_sram: 2^ADDR_W-byte SRAM, one access per cycle, DATA_BYTES
// consecutive bytes per access with modulo wrap, per-byte write strobes and
// a RD_LAT (1 or 2) cycle pipelined read returning pre-write data.
// Optional feature macro HEAP_SRAM_CLEAR_EN: reset zeroes the whole memory,
// one word per cycle, before ready rises; without it reset enters READY
// directly and memory contents persist.
module heap_byte_sram #(
  parameter int DATA_BYTES = 4,
  parameter int ADDR_W     = 16,
  parameter int RD_LAT     = 1
) (
  input logic              clk,
  input logic              rst,
  heap_byte_sram_if.slave  bus
);
  localparam int W      = 8 * DATA_BYTES;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LB     = $clog2(DATA_BYTES);
  localparam int CNT_W  = (ADDR_W > LB) ? ADDR_W - LB : 1;
  localparam int NWORDS = DEPTH / DATA_BYTES;

`ifdef HEAP_SRAM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_READY} state_e;
`else
  typedef enum logic {S_READY} state_e;
`endif

  logic [7:0]  mem_q [DEPTH];
  state_e      state_q, state_d;
  logic        ready;
  logic        accept, wr_acc, rd_acc;

  logic [ADDR_W-1:0] lane_addr [DATA_BYTES];
  logic [7:0]        lane_wd   [DATA_BYTES];
  logic [DATA_BYTES-1:0] lane_we;
  logic [W-1:0]      rd_word;

  logic [W-1:0] q_q, q_d, pipe_q, pipe_d;
  logic         rvalid_q, rvalid_d, pipe_vld_q, pipe_vld_d;

`ifdef HEAP_SRAM_CLEAR_EN
  logic [CNT_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             clr_active;
`endif

  assign ready      = (state_q == S_READY);
  assign accept     = bus.req & ready & ~rst;
  assign wr_acc     = accept & bus.wen;
  assign rd_acc     = accept & ~bus.wen;
  assign bus.ready  = ready;
  assign bus.rvalid = rvalid_q;
  assign bus.q      = q_q;

  // Next state: reset parks the FSM, the clear walk ends after the last word.
  always_comb begin
    state_d = state_q;
`ifdef HEAP_SRAM_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
    clr_active = 1'b0;
    if (rst) begin
      state_d   = S_CLEAR;
      clr_cnt_d = '0;
    end else if (state_q == S_CLEAR) begin
      clr_active = 1'b1;
      clr_cnt_d  = clr_cnt_q + 1'b1;
      if (clr_cnt_q == CNT_W'(NWORDS - 1)) state_d = S_READY;
    end
`else
    if (rst) state_d = S_READY;
`endif
  end

  // Per-lane addresses with wrap; the clear walk takes over the write lanes.
  always_comb begin
    rd_word = '0;
    lane_we = '0;
    for (int k = 0; k < DATA_BYTES; k++) begin
      lane_addr[k] = bus.addr + ADDR_W'(k);
      lane_wd[k]   = bus.d[8*k +: 8];
      lane_we[k]   = wr_acc & bus.be[k];
      rd_word[8*k +: 8] = mem_q[lane_addr[k]];
`ifdef HEAP_SRAM_CLEAR_EN
      if (clr_active) begin
        lane_addr[k] = (ADDR_W'(clr_cnt_q) << LB) | ADDR_W'(k);
        lane_wd[k]   = 8'h00;
        lane_we[k]   = 1'b1;
      end
`endif
    end
  end

  // Read return path: data captured at the accepting edge (read-before-write).
  always_comb begin
    pipe_d     = pipe_q;
    pipe_vld_d = 1'b0;
    q_d        = q_q;
    rvalid_d   = 1'b0;
    if (RD_LAT == 2) begin
      pipe_vld_d = rd_acc;
      if (rd_acc) pipe_d = rd_word;
      if (pipe_vld_q) begin
        q_d      = pipe_q;
        rvalid_d = 1'b1;
      end
    end else if (rd_acc) begin
      q_d      = rd_word;
      rvalid_d = 1'b1;
    end
    if (rst) begin
      pipe_vld_d = 1'b0;
      q_d        = '0;
      rvalid_d   = 1'b0;
    end
  end

  // Control and read-path registers.
  always_ff @(posedge clk) begin
    state_q    <= state_d;
    pipe_q     <= pipe_d;
    pipe_vld_q <= pipe_vld_d;
    q_q        <= q_d;
    rvalid_q   <= rvalid_d;
`ifdef HEAP_SRAM_CLEAR_EN
    clr_cnt_q  <= clr_cnt_d;
`endif
  end

  // Byte-lane memory writes; storage itself is never reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DATA_BYTES; k++) begin
      if (lane_we[k]) mem_q[lane_addr[k]] <= lane_wd[k];
    end
  end
endmodule

// File: tb/tb_heap_byte_sram.sv
// Testbench for heap_byte_sram: two instances (RD_LAT=1 and RD_LAT=2) driven
// with identical stimulus, a byte-level reference model and per-instance
// expected-read queues. With HEAP_SRAM_CLEAR_EN a third small instance
// (ADDR_W=6) exercises the clear sequence.
module tb_heap_byte_sram;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  heap_byte_sram_if #(.DATA_BYTES(4), .ADDR_W(16)) bus1 ();
  heap_byte_sram_if #(.DATA_BYTES(4), .ADDR_W(16)) bus2 ();

  heap_byte_sram #(.DATA_BYTES(4), .ADDR_W(16), .RD_LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  heap_byte_sram #(.DATA_BYTES(4), .ADDR_W(16), .RD_LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // Reference memory; known[] marks bytes the bench has defined.
  logic [7:0] model_mem [65536];
  bit         known     [65536];

  // Scoreboards: expected data, compare mask, cycle of the rvalid pulse.
  logic [31:0] exp_q1[$], msk_q1[$];
  int          due_q1[$];
  logic [31:0] exp_q2[$], msk_q2[$];
  int          due_q2[$];

  typedef struct {
    logic        wen;
    logic [3:0]  be;
    logic [15:0] addr;
    logic [31:0] d;
    logic [31:0] exp;
    logic [31:0] msk;
  } vec_t;

  localparam int NV = 17;
  vec_t vec [NV];

  task automatic model_read(input logic [15:0] a, output logic [31:0] e, output logic [31:0] m);
    logic [15:0] ba;
    e = '0;
    m = '0;
    for (int k = 0; k < 4; k++) begin
      ba = a + 16'(k);
      if (known[ba]) begin
        e[8*k +: 8] = model_mem[ba];
        m[8*k +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic model_write(input logic [3:0] b, input logic [15:0] a, input logic [31:0] dd);
    logic [15:0] ba;
    for (int k = 0; k < 4; k++) begin
      ba = a + 16'(k);
      if (b[k]) begin
        model_mem[ba] = dd[8*k +: 8];
        known[ba]     = 1'b1;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 65536; i++) begin
      model_mem[i] = 8'h00;
      known[i]     = 1'b1;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    bus1.req = 1'b0;
    bus2.req = 1'b0;
  endtask

  // One request on both instances; reads push expectations, writes update the model.
  task automatic op(input logic w, input logic [3:0] b, input logic [15:0] a,
                    input logic [31:0] dd, input logic [31:0] e, input logic [31:0] m,
                    input bit use_model, input bit skip2);
    @(negedge clk);
    checks++;
    if (!(bus1.ready && bus2.ready)) begin
      errors++;
      $display("FAIL ready_before_op ready1=%0b ready2=%0b required 1", bus1.ready, bus2.ready);
    end
    bus1.req = 1'b1; bus1.wen = w; bus1.be = b; bus1.addr = a; bus1.d = dd;
    bus2.req = 1'b1; bus2.wen = w; bus2.be = b; bus2.addr = a; bus2.d = dd;
    if (w) begin
      model_write(b, a, dd);
    end else begin
      if (use_model) model_read(a, e, m);
      exp_q1.push_back(e); msk_q1.push_back(m); due_q1.push_back(cyc + 1);
      if (!skip2) begin
        exp_q2.push_back(e); msk_q2.push_back(m); due_q2.push_back(cyc + 2);
      end
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!(bus1.ready && bus2.ready) && n < 40000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(bus1.ready && bus2.ready)) begin
      errors++;
      $display("FAIL ready_timeout ready1=%0b ready2=%0b required 1", bus1.ready, bus2.ready);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus1.req = 1'b0;
    bus2.req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus1.q !== 32'h0 || bus2.q !== 32'h0 || bus1.rvalid !== 1'b0 || bus2.rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs q1=%h q2=%h rv1=%b rv2=%b required q=0 rvalid=0",
               bus1.q, bus2.q, bus1.rvalid, bus2.rvalid);
    end
    rst = 1'b0;
    @(negedge clk);
`ifdef HEAP_SRAM_CLEAR_EN
    checks++;
    if (bus1.ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_during_clear ready1=%b required 0", bus1.ready);
    end
    model_clear();
    wait_ready();
`else
    checks++;
    if (bus1.ready !== 1'b1 || bus2.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset ready1=%b ready2=%b required 1", bus1.ready, bus2.ready);
    end
`endif
  endtask

  logic [31:0] e1, m1, e2, m2;
  int          d1, d2;

  // Return-path monitor for the RD_LAT=1 instance.
  always @(negedge clk) begin
    if (bus1.rvalid === 1'b1) begin
      checks++;
      if (exp_q1.size() == 0) begin
        errors++;
        $display("FAIL rd1_unexpected rvalid at cyc %0d q=%h required no pulse", cyc, bus1.q);
      end else begin
        e1 = exp_q1.pop_front(); m1 = msk_q1.pop_front(); d1 = due_q1.pop_front();
        if (((bus1.q ^ e1) & m1) !== 32'h0 || d1 != cyc) begin
          errors++;
          $display("FAIL rd1_data q=%h cyc=%0d required q=%h (mask %h) cyc=%0d", bus1.q, cyc, e1, m1, d1);
        end
      end
    end else if (due_q1.size() > 0 && due_q1[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rd1_missing no rvalid at cyc %0d required q=%h", cyc, exp_q1[0]);
      void'(exp_q1.pop_front()); void'(msk_q1.pop_front()); void'(due_q1.pop_front());
    end
  end

  // Return-path monitor for the RD_LAT=2 instance.
  always @(negedge clk) begin
    if (bus2.rvalid === 1'b1) begin
      checks++;
      if (exp_q2.size() == 0) begin
        errors++;
        $display("FAIL rd2_unexpected rvalid at cyc %0d q=%h required no pulse", cyc, bus2.q);
      end else begin
        e2 = exp_q2.pop_front(); m2 = msk_q2.pop_front(); d2 = due_q2.pop_front();
        if (((bus2.q ^ e2) & m2) !== 32'h0 || d2 != cyc) begin
          errors++;
          $display("FAIL rd2_data q=%h cyc=%0d required q=%h (mask %h) cyc=%0d", bus2.q, cyc, e2, m2, d2);
        end
      end
    end else if (due_q2.size() > 0 && due_q2[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL rd2_missing no rvalid at cyc %0d required q=%h", cyc, exp_q2[0]);
      void'(exp_q2.pop_front()); void'(msk_q2.pop_front()); void'(due_q2.pop_front());
    end
  end

`ifdef HEAP_SRAM_CLEAR_EN
  logic rst_c = 1'b1;
  heap_byte_sram_if #(.DATA_BYTES(4), .ADDR_W(6)) busc ();
  heap_byte_sram #(.DATA_BYTES(4), .ADDR_W(6), .RD_LAT(1)) dutc (.clk(clk), .rst(rst_c), .bus(busc));

  // Counts cycles with ready=0 from the current negedge, hammering a write that must be ignored.
  task automatic count_clear(input int stop_at, output int n);
    n = 0;
    while (busc.ready !== 1'b1 && n < 100 && n < stop_at) begin
      busc.req = 1'b1; busc.wen = 1'b1; busc.be = 4'hF; busc.addr = 6'h0; busc.d = 32'hFFFF_FFFF;
      n++;
      @(negedge clk);
    end
    busc.req = 1'b0;
  endtask

  task automatic clear_test();
    int n;
    busc.req = 1'b0; busc.wen = 1'b0; busc.be = '0; busc.addr = '0; busc.d = '0;
    @(negedge clk); rst_c = 1'b1;
    repeat (2) @(negedge clk);
    rst_c = 1'b0;
    count_clear(5, n);
    rst_c = 1'b1;
    @(negedge clk);
    rst_c = 1'b0;
    count_clear(1000, n);
    checks++;
    if (n != 16) begin
      errors++;
      $display("FAIL clear_length ready low for %0d cycles required 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      busc.req = 1'b1; busc.wen = 1'b0; busc.addr = 6'(i * 4);
      @(negedge clk);
      busc.req = 1'b0;
      checks++;
      if (busc.rvalid !== 1'b1 || busc.q !== 32'h0) begin
        errors++;
        $display("FAIL clear_read addr=%0d rvalid=%b q=%h required rvalid=1 q=0", i * 4, busc.rvalid, busc.q);
      end
    end
  endtask
`endif

  initial begin
    vec[0]  = '{1'b1, 4'hF, 16'h0010, 32'h1122_3344, 32'h0, 32'h0};
    vec[1]  = '{1'b0, 4'h0, 16'h0010, 32'h0, 32'h1122_3344, 32'hFFFF_FFFF};
    vec[2]  = '{1'b1, 4'h5, 16'h0010, 32'hAABB_CCDD, 32'h0, 32'h0};
    vec[3]  = '{1'b0, 4'h0, 16'h0010, 32'h0, 32'h11BB_33DD, 32'hFFFF_FFFF};
    vec[4]  = '{1'b0, 4'h0, 16'h0012, 32'h0, 32'h0000_11BB, 32'h0000_FFFF};
    vec[5]  = '{1'b1, 4'hF, 16'hFFFE, 32'hDEAD_BEEF, 32'h0, 32'h0};
    vec[6]  = '{1'b0, 4'h0, 16'h0000, 32'h0, 32'h0000_DEAD, 32'h0000_FFFF};
    vec[7]  = '{1'b0, 4'h0, 16'hFFFE, 32'h0, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vec[8]  = '{1'b1, 4'hF, 16'h0020, 32'h0102_0304, 32'h0, 32'h0};
    vec[9]  = '{1'b1, 4'h0, 16'h0020, 32'hFFFF_FFFF, 32'h0, 32'h0};
    vec[10] = '{1'b0, 4'h0, 16'h0020, 32'h0, 32'h0102_0304, 32'hFFFF_FFFF};
    vec[11] = '{1'b1, 4'hF, 16'h0014, 32'h5566_7788, 32'h0, 32'h0};
    vec[12] = '{1'b0, 4'h0, 16'h0010, 32'h0, 32'h11BB_33DD, 32'hFFFF_FFFF};
    vec[13] = '{1'b0, 4'h0, 16'h0014, 32'h0, 32'h5566_7788, 32'hFFFF_FFFF};
    vec[14] = '{1'b1, 4'hA, 16'h0021, 32'h7700_6600, 32'h0, 32'h0};
    vec[15] = '{1'b0, 4'h0, 16'h0020, 32'h0, 32'h0166_0304, 32'hFFFF_FFFF};
    vec[16] = '{1'b0, 4'h0, 16'h0021, 32'h0, 32'h7701_6603, 32'hFFFF_FFFF};

    bus1.req = 1'b0; bus1.wen = 1'b0; bus1.be = '0; bus1.addr = '0; bus1.d = '0;
    bus2.req = 1'b0; bus2.wen = 1'b0; bus2.be = '0; bus2.addr = '0; bus2.d = '0;
    for (int i = 0; i < 65536; i++) known[i] = 1'b0;

    do_reset();

    // Directed vectors, one request per cycle (reads 12/13 are back-to-back).
    for (int i = 0; i < NV; i++)
      op(vec[i].wen, vec[i].be, vec[i].addr, vec[i].d, vec[i].exp, vec[i].msk, 1'b0, 1'b0);
    idle();

    // A read followed by a write to the same word while the read is in flight.
    op(1'b0, 4'h0, 16'h0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    op(1'b1, 4'hF, 16'h0010, 32'h9988_7766, 32'h0, 32'h0, 1'b1, 1'b0);
    op(1'b0, 4'h0, 16'h0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();
    repeat (3) idle();

    // Reset one edge after an accepted read: the RD_LAT=2 read must vanish.
    op(1'b0, 4'h0, 16'h0014, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    do_reset();
    op(1'b0, 4'h0, 16'h0010, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Random traffic over a small window plus the wrap boundary.
    for (int i = 0; i < 200; i++) begin
      logic [15:0] a;
      if ($urandom_range(0, 3) == 0) a = 16'hFFFC + 16'($urandom_range(0, 3));
      else a = 16'($urandom_range(0, 63));
      if ($urandom_range(0, 4) == 0) idle();
      else if ($urandom_range(0, 1) == 0)
        op(1'b1, 4'($urandom_range(0, 15)), a, $urandom, 32'h0, 32'h0, 1'b1, 1'b0);
      else
        op(1'b0, 4'h0, a, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    idle();
    repeat (4) idle();

    checks++;
    if (exp_q1.size() != 0 || exp_q2.size() != 0) begin
      errors++;
      $display("FAIL drain pending1=%0d pending2=%0d required 0", exp_q1.size(), exp_q2.size());
    end

`ifdef HEAP_SRAM_CLEAR_EN
    clear_test();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
